// File: rtl/fpu_seq_alu_if.sv
// Request/response bundle for the multi-cycle floating-point ALU.
// The master side issues operations; the slave side is the ALU itself.
interface fpu_seq_alu_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic [2:0]   op;
    logic [1:0]   cmp_cond;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic         flag_clr;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         com_result;
    logic         DIVZ;
    logic         QNAN;
    logic         SNAN;
    logic         INEX;
    logic         UNFL;
    logic         OVFL;

    modport master (
        output start, op, cmp_cond, operand1, operand2, flag_clr,
        input  busy, done, result, com_result, DIVZ, QNAN, SNAN, INEX, UNFL, OVFL
    );

    modport slave (
        input  start, op, cmp_cond, operand1, operand2, flag_clr,
        output busy, done, result, com_result, DIVZ, QNAN, SNAN, INEX, UNFL, OVFL
    );
endinterface

// File: rtl/fpu_seq_alu.sv
// Multi-cycle floating-point ALU: unpack, compute (iterative divide), normalise, pack.
// Round-toward-zero, subnormals-as-zero, sticky exception flags.
module fpu_seq_alu #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic          clk,
    input logic          rst,
    fpu_seq_alu_if.slave bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = MAN_W + 1;
    localparam int EXT  = MW + 3;
    localparam int XW   = EXP_W + 3;
    localparam int QW   = MAN_W + 2;
    localparam int CW   = $clog2(QW + 1);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_BIG = EXP_MAX - 1'b1;
    localparam logic [W-1:0]     QNAN_VAL = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, UNPACK, EXEC, PACK} state_t;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_INV, OP_ABS, OP_COM, OP_RSV} op_t;
    typedef struct packed {
        logic divz, qnan, snan, inex, unfl, ovfl;
    } flags_t;

    state_t state;
    logic   busy_q, done_q, com_q;
    logic [W-1:0] result_q;
    flags_t flags_q;

    logic [W-1:0] a_q, b_q;
    op_t          op_q;
    logic [1:0]   cmp_q;
    logic [W-1:0] fin_res;
    logic         fin_com, fin_com_we, fin_direct;
    flags_t       fin_flags;
    logic         n_sign, n_inex, n_zero;
    logic signed [XW-1:0] n_exp;
    logic [MAN_W-1:0]     n_man;
    logic [MW:0]   rem_q;
    logic [QW-1:0] quo_q;
    logic [CW-1:0] cnt_q;

    function automatic int lzc(input logic [EXT:0] v);
        lzc = EXT + 1;
        for (int i = 0; i <= EXT; i++)
            if (v[i]) lzc = EXT - i;
    endfunction

    // Operand field decode (DAZ: exponent zero means zero)
    logic a_sign, b_sign, b_eff_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic [MW-1:0]    a_sig, b_sig;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, any_nan, any_snan;

    assign {a_sign, a_exp, a_man} = a_q;
    assign {b_sign, b_exp, b_man} = b_q;
    assign a_sig      = {1'b1, a_man};
    assign b_sig      = {1'b1, b_man};
    assign b_eff_sign = b_sign ^ (op_q == OP_SUB);
    assign a_zero     = (a_exp == '0);
    assign b_zero     = (b_exp == '0);
    assign a_inf      = (a_exp == EXP_MAX) && (a_man == '0);
    assign b_inf      = (b_exp == EXP_MAX) && (b_man == '0);
    assign a_nan      = (a_exp == EXP_MAX) && (a_man != '0);
    assign b_nan      = (b_exp == EXP_MAX) && (b_man != '0);
    assign any_nan    = a_nan || b_nan;
    assign any_snan   = (a_nan && !a_man[MAN_W-1]) || (b_nan && !b_man[MAN_W-1]);

    // Ordered compare on sign-magnitude keys; -0 and +0 collapse to the same key
    logic signed [W:0] a_key, b_key;
    logic [W-1:0]      a_mag, b_mag;
    always_comb begin
        a_mag = a_zero ? '0 : {1'b0, a_q[W-2:0]};
        b_mag = b_zero ? '0 : {1'b0, b_q[W-2:0]};
        a_key = a_sign ? -$signed({1'b0, a_mag}) : $signed({1'b0, a_mag});
        b_key = b_sign ? -$signed({1'b0, b_mag}) : $signed({1'b0, b_mag});
    end

    // Results that are fully determined at unpack time
    logic         spec_hit, spec_com, spec_com_we;
    logic [W-1:0] spec_res;
    flags_t       spec_flags;
    always_comb begin
        spec_hit    = 1'b1;
        spec_res    = '0;
        spec_com    = 1'b0;
        spec_com_we = 1'b0;
        spec_flags  = '0;
        case (op_q)
            OP_INV: spec_res = {~a_sign, a_q[W-2:0]};
            OP_ABS: spec_res = {1'b0, a_q[W-2:0]};
            OP_RSV: spec_com_we = 1'b1;
            OP_COM: begin
                spec_com_we     = 1'b1;
                spec_flags.qnan = any_nan;
                spec_flags.snan = any_snan;
                if (any_nan) begin
                    spec_res = W'(2);
                    spec_com = (cmp_q == 2'd3);
                end else if (a_key < b_key) begin
                    spec_res = '1;
                    spec_com = (cmp_q == 2'd0);
                end else if (a_key > b_key) begin
                    spec_res = W'(1);
                    spec_com = (cmp_q == 2'd2);
                end else begin
                    spec_com = (cmp_q == 2'd1);
                end
            end
            default: begin
                if (any_nan) begin
                    spec_res        = QNAN_VAL;
                    spec_flags.qnan = 1'b1;
                    spec_flags.snan = any_snan;
                end else if (op_q == OP_ADD || op_q == OP_SUB) begin
                    if (a_inf && b_inf && (a_sign != b_eff_sign)) begin
                        spec_res        = QNAN_VAL;
                        spec_flags.qnan = 1'b1;
                    end else if (a_inf)          spec_res = {a_sign, EXP_MAX, {MAN_W{1'b0}}};
                    else if (b_inf)              spec_res = {b_eff_sign, EXP_MAX, {MAN_W{1'b0}}};
                    else if (a_zero && b_zero)   spec_res = '0;
                    else if (a_zero)             spec_res = {b_eff_sign, b_q[W-2:0]};
                    else if (b_zero)             spec_res = a_q;
                    else                         spec_hit = 1'b0;
                end else if (op_q == OP_MUL) begin
                    if ((a_zero && b_inf) || (a_inf && b_zero)) begin
                        spec_res        = QNAN_VAL;
                        spec_flags.qnan = 1'b1;
                    end else if (a_inf || b_inf)   spec_res = {a_sign ^ b_sign, EXP_MAX, {MAN_W{1'b0}}};
                    else if (a_zero || b_zero)     spec_res = {a_sign ^ b_sign, {(W-1){1'b0}}};
                    else                           spec_hit = 1'b0;
                end else begin
                    if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                        spec_res        = QNAN_VAL;
                        spec_flags.qnan = 1'b1;
                    end else if (a_inf) begin
                        spec_res = {a_sign ^ b_sign, EXP_MAX, {MAN_W{1'b0}}};
                    end else if (b_zero) begin
                        spec_res        = {a_sign ^ b_sign, EXP_MAX, {MAN_W{1'b0}}};
                        spec_flags.divz = 1'b1;
                    end else if (a_zero || b_inf) begin
                        spec_res = {a_sign ^ b_sign, {(W-1){1'b0}}};
                    end else begin
                        spec_hit = 1'b0;
                    end
                end
            end
        endcase
    end

    // ADD/SUB: align the smaller magnitude, keep guard/round/sticky, normalise by LZC
    logic             a_big, big_sign, sml_sign, sticky;
    logic [EXP_W-1:0] big_exp, sml_exp, diff;
    logic [MW-1:0]    big_sig, sml_sig;
    logic [EXT-1:0]   sml_ext0, sml_ext;
    logic [EXT:0]     sum, norm;
    int               lz;
    always_comb begin
        a_big    = (a_q[W-2:0] >= b_q[W-2:0]);
        big_sign = a_big ? a_sign : b_eff_sign;
        sml_sign = a_big ? b_eff_sign : a_sign;
        big_exp  = a_big ? a_exp : b_exp;
        sml_exp  = a_big ? b_exp : a_exp;
        big_sig  = a_big ? a_sig : b_sig;
        sml_sig  = a_big ? b_sig : a_sig;
        diff     = big_exp - sml_exp;
        sml_ext0 = {sml_sig, 3'b000};
        if (int'(diff) >= EXT) begin
            sml_ext = '0;
            sticky  = 1'b1;
        end else begin
            sml_ext = sml_ext0 >> diff;
            sticky  = |(sml_ext0 & ~({EXT{1'b1}} << diff));
        end
        sml_ext[0] = sml_ext[0] | sticky;
        sum = (big_sign == sml_sign) ? {1'b0, big_sig, 3'b000} + {1'b0, sml_ext}
                                     : {1'b0, big_sig, 3'b000} - {1'b0, sml_ext};
        lz   = lzc(sum);
        norm = sum[EXT] ? {1'b0, sum[EXT:2], sum[1] | sum[0]} : (sum << (lz - 1));
    end

    // MUL: full product, at most one bit of normalisation
    logic [2*MW-1:0] prod;
    logic            mul_hi;
    assign prod   = a_sig * b_sig;
    assign mul_hi = prod[2*MW-1];

    // DIV: one restoring step per EXEC cycle
    logic          rem_ge, div_hi;
    logic [MW:0]   rem_sub;
    assign rem_ge  = (rem_q >= {1'b0, b_sig});
    assign rem_sub = rem_ge ? rem_q - {1'b0, b_sig} : rem_q;
    assign div_hi  = quo_q[QW-1];

    // Final rounding/range handling for computed results
    logic [W-1:0] pack_res;
    flags_t       pack_flags;
    always_comb begin
        pack_res   = fin_res;
        pack_flags = fin_flags;
        if (!fin_direct) begin
            pack_flags = '0;
            if (n_zero) begin
                pack_res = '0;
            end else if (n_exp >= $signed(XW'(EXP_MAX))) begin
                pack_res        = {n_sign, EXP_BIG, {MAN_W{1'b1}}};
                pack_flags.ovfl = 1'b1;
                pack_flags.inex = 1'b1;
            end else if (n_exp < 1) begin
                pack_res        = {n_sign, {(W-1){1'b0}}};
                pack_flags.unfl = 1'b1;
                pack_flags.inex = 1'b1;
            end else begin
                pack_res        = {n_sign, n_exp[EXP_W-1:0], n_man};
                pack_flags.inex = n_inex;
            end
        end
    end

    // NOTE: datapath registers carry no reset; each is written before the FSM reads it.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (bus.start) begin
                a_q   <= bus.operand1;
                b_q   <= bus.operand2;
                op_q  <= op_t'(bus.op);
                cmp_q <= bus.cmp_cond;
            end
            UNPACK: begin
                fin_res    <= spec_res;
                fin_com    <= spec_com;
                fin_com_we <= spec_com_we;
                fin_flags  <= spec_flags;
                fin_direct <= spec_hit;
                rem_q      <= {1'b0, a_sig};
                quo_q      <= '0;
                cnt_q      <= '0;
            end
            EXEC: begin
                n_zero <= 1'b0;
                if (op_q == OP_DIV) begin
                    if (cnt_q == CW'(QW)) begin
                        n_sign <= a_sign ^ b_sign;
                        n_exp  <= XW'(int'(a_exp) - int'(b_exp) + BIAS - 1 + int'(div_hi));
                        n_man  <= div_hi ? quo_q[QW-2:1] : quo_q[QW-3:0];
                        n_inex <= (rem_q != '0) || (div_hi && quo_q[0]);
                    end else begin
                        rem_q <= rem_sub << 1;
                        quo_q <= {quo_q[QW-2:0], rem_ge};
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else if (op_q == OP_MUL) begin
                    n_sign <= a_sign ^ b_sign;
                    n_exp  <= XW'(int'(a_exp) + int'(b_exp) - BIAS + int'(mul_hi));
                    n_man  <= mul_hi ? prod[2*MW-2 -: MAN_W] : prod[2*MW-3 -: MAN_W];
                    n_inex <= mul_hi ? |prod[MW-1:0] : |prod[MW-2:0];
                end else begin
                    n_sign <= big_sign;
                    n_exp  <= XW'(int'(big_exp) + 1 - lz);
                    n_man  <= norm[EXT-2:3];
                    n_inex <= |norm[2:0];
                    n_zero <= (sum == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            com_q    <= 1'b0;
            flags_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            // A completing op's flags are ORed after the clear, so set wins
            flags_q <= (bus.flag_clr ? '0 : flags_q) | ((state == PACK) ? pack_flags : '0);
            case (state)
                IDLE: if (bus.start) begin
                    busy_q <= 1'b1;
                    state  <= UNPACK;
                end
                UNPACK: state <= spec_hit ? PACK : EXEC;
                EXEC: if (op_q != OP_DIV || cnt_q == CW'(QW)) state <= PACK;
                PACK: begin
                    result_q <= pack_res;
                    if (fin_com_we) com_q <= fin_com;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.com_result = com_q;
    assign bus.DIVZ       = flags_q.divz;
    assign bus.QNAN       = flags_q.qnan;
    assign bus.SNAN       = flags_q.snan;
    assign bus.INEX       = flags_q.inex;
    assign bus.UNFL       = flags_q.unfl;
    assign bus.OVFL       = flags_q.ovfl;
endmodule

// File: doc/fpu_seq_alu.md
# fpu_seq_alu

Parametrised, multi-cycle floating-point ALU: the successor to the single-cycle FPU ALU. It supports configurable exponent and mantissa widths and a start/busy/done handshake. It performs real IEEE-754-style unpack, compute, normalise and pack, including an iterative divider, and accumulates sticky exception flags. It sits between the FP register file and the branch/writeback logic of the FPU datapath.

## Interface
- EXP_W, 8, exponent width.
- MAN_W, 23, stored mantissa width (hidden bit excluded). W = 1+EXP_W+MAN_W.
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Accepted only in IDLE.
- op  in  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 INV (negate), 5 ABS, 6 COM, 7 reserved.
- cmp_cond  in  2  COM predicate: 0 BLT, 1 BEQ, 2 BGT, 3 unordered-test.
- operand1, operand2  in  W  sampled at acceptance.
- flag_clr  in  1  clears sticky flags.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- result  out  W  last completed result, held.
- com_result  out  1  COM predicate outcome, held.
- DIVZ, QNAN, SNAN, INEX, UNFL, OVFL  out  1 each  sticky exception flags.

## Operation
- FSM states: IDLE, UNPACK, EXEC, PACK.
  - IDLE→UNPACK on start.
  - UNPACK→PACK for simple/special cases.
  - UNPACK→EXEC otherwise.
  - EXEC holds for DIV iterations, then →PACK.
  - PACK→IDLE, asserting done.
- Operands are latched at acceptance. start while busy is ignored.
- Subnormal inputs are treated as signed zero (DAZ).
- Rounding is toward zero. INEX is set when any discarded bit is nonzero.
- Overflow: result is the largest finite magnitude with the result sign (exp = all-ones−1, mantissa all ones); OVFL and INEX are set.
- Underflow: a nonzero result whose normalised exponent is < 1 flushes to signed zero; UNFL and INEX are set.
- ADD/SUB:
  - Align by exponent difference; shifted-out bits feed a sticky bit.
  - Normalise with a leading-zero count.
  - An exact zero result is +0.
- MUL: full (MAN_W+1)×(MAN_W+1) product, normalised by at most 1 bit.
- DIV: restoring divider producing MAN_W+2 quotient bits, one per EXEC cycle. A nonzero remainder sets INEX.
- Specials:
  - NaN = exp all-ones, mantissa ≠0. A NaN is signalling if the mantissa MSB is 0.
  - Any NaN operand to ADD/SUB/MUL/DIV gives canonical qNaN (sign 0, exp all-ones, mantissa MSB 1, rest 0) and sets QNAN. SNAN is also set if any operand is signalling.
  - inf−inf, 0×inf, 0/0 and inf/inf give qNaN and set QNAN.
  - finite-nonzero/0 gives signed inf and sets DIVZ.
- INV flips the operand1 sign bit; ABS clears it. Both are pure bit operations with no flags, NaN included.
- COM:
  - result = all-ones if op1<op2, 0 if equal, 1 if op1>op2, 2 if unordered.
  - −0 equals +0.
  - com_result = predicate per cmp_cond. Any unordered compare gives 0 for BLT/BEQ/BGT and 1 for cmp_cond=3.
  - A NaN operand sets QNAN; SNAN is also set if signalling.
- Reserved op: result 0, com_result 0, no flags.
- Flags are ORed in on done.
  - flag_clr clears them.
  - If flag_clr coincides with done, the completing op's flags survive (set wins).

## Timing
- Acceptance edge k: busy=1 from k+1 until done.
- Latency L (done high in cycle after edge k+L):
  - L=2 for INV, ABS, COM, reserved, and special-case operands.
  - L=3 for ADD/SUB/MUL.
  - L=MAN_W+5 for DIV (28 at default).
- result, com_result and flags update in the same cycle done is high, then hold until the next done.
- busy falls with done. A new start is accepted in the cycle after done (back-to-back throughput 1 op per L+1 cycles).
- Reset values: state IDLE, busy 0, done 0, result 0, com_result 0, all flags 0.
- rst mid-operation aborts the operation, with no done and no flag update. rst dominates start and flag_clr.

## Test plan
- ADD 3FC00000 + 40100000 → result 40700000, done exactly 3 cycles after acceptance, no flags.
- DIV 3F800000 / 40400000 → 3EAAAAAA, INEX=1, done 28 cycles after acceptance. A start pulse at cycle 5 is ignored (busy=1, no second done).
- DIV 40000000 / 00000000 → 7F800000, DIVZ=1. Then flag_clr → all flags 0 next cycle, result held.
- MUL 7F000000 × 7F000000 → 7F7FFFFF, OVFL=1, INEX=1. Then MUL 00800000 × 00800000 → 00000000, UNFL=1.
- ADD 7F800001 + 3F800000 → 7FC00000, SNAN=1, QNAN=1. COM 80000000 vs 00000000 with BEQ → result 0, com_result 1; with cmp_cond=3 → com_result 0.
- Start DIV, assert rst at cycle 10 → busy 0 and all outputs at reset values next cycle, no done. The next ADD completes normally.
